// File: rtl/cashier_pkg.sv
// Shared definitions for the change dispenser: denomination codes, their
// face values, default widths and the dispenser state encoding.
package cashier_pkg;

    // Default width of a change amount; matches the cashier result bus.
    localparam int CHANGE_WIDTH = 16;

    // Default width of the per-transaction piece counter.
    // The worst case, 59999, breaks into 29 pieces, so 5 bits always suffice.
    localparam int COUNT_WIDTH = 5;

    // Number of physical denominations the hopper can dispense.
    localparam int NUM_DENOMS = 8;

    // Denomination codes, largest face value first.
    // A lower code always means a larger coin or note.
    typedef enum logic [2:0] {
        DEN_10000 = 3'd0,
        DEN_5000  = 3'd1,
        DEN_1000  = 3'd2,
        DEN_500   = 3'd3,
        DEN_100   = 3'd4,
        DEN_50    = 3'd5,
        DEN_10    = 3'd6,
        DEN_1     = 3'd7
    } denom_e;

    // Face value of each denomination, indexed by its code.
    localparam logic [CHANGE_WIDTH-1:0] DENOM_VALUE [0:NUM_DENOMS-1] = '{
        16'd10000,
        16'd5000,
        16'd1000,
        16'd500,
        16'd100,
        16'd50,
        16'd10,
        16'd1
    };

    // Dispenser control states.
    //   IDLE     : waiting for a cashier result
    //   DISPENSE : offering one piece per cycle to the hopper
    //   DONE     : single-cycle completion marker, then back to IDLE
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the cashier result inputs, the hopper handshake and the front
// panel status lines seen by the change dispenser.
// The dispenser sits on the slave side.
// The master side drives the cashier result and the hopper ready, and
// observes everything else.
interface change_dispenser_if
    import cashier_pkg::*;
#(
    parameter int CHANGE_W = CHANGE_WIDTH,
    parameter int CNT_W    = COUNT_WIDTH
);

    // Cashier result: a one-cycle valid pulse carrying paid and change.
    logic                valid;
    logic                paid;
    logic [CHANGE_W-1:0] change;

    // Hopper handshake: one denomination code per accepted transfer.
    logic                coin_ready;
    logic                coin_valid;
    logic [2:0]          coin_denom;

    // Front panel status.
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    coin_count;
    logic                drop;

    // Cashier and hopper side.
    modport master (
        output valid,
        output paid,
        output change,
        output coin_ready,
        input  coin_valid,
        input  coin_denom,
        input  busy,
        input  done,
        input  coin_count,
        input  drop
    );

    // Dispenser side.
    modport slave (
        input  valid,
        input  paid,
        input  change,
        input  coin_ready,
        output coin_valid,
        output coin_denom,
        output busy,
        output done,
        output coin_count,
        output drop
    );

endinterface

// File: rtl/denom_select.sv
// Greedy denomination picker.
// It returns the largest denomination whose face value does not exceed the
// remaining amount, along with that value.
// A zero amount yields code 0 with value 0.
// The dispenser never offers a piece in that case, and the decoded denom
// output then reads as zero.
module denom_select
    import cashier_pkg::*;
#(
    parameter int W = CHANGE_WIDTH
) (
    input  logic [W-1:0] remaining,
    output denom_e       code,
    output logic [W-1:0] value
);

    // Priority compare: scan from the smallest denomination up, so the last
    // match that sticks is the largest one that still fits.
    always_comb begin
        // NOTE: both outputs get a default before any conditional assignment,
        // so no path through this block leaves them unassigned and no latch
        // is inferred.
        code  = DEN_10000;
        value = '0;
        for (int i = NUM_DENOMS - 1; i >= 0; i--) begin
            if (remaining >= W'(DENOM_VALUE[i])) begin
                code  = denom_e'(3'(i));
                value = W'(DENOM_VALUE[i]);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser.
// It captures a completed cashier transaction and hands the change to a
// coin/note hopper one piece per valid/ready handshake, largest denomination
// first.
// It reports busy, completion, the number of pieces dispensed, and any
// result that arrived while it was still busy.
module change_dispenser
    import cashier_pkg::*;
#(
    parameter int CHANGE_W = CHANGE_WIDTH,
    parameter int CNT_W    = COUNT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    change_dispenser_if.slave  bus
);

    // Control state.
    state_e              state_q;
    state_e              state_d;

    // Amount still to be dispensed for the current transaction.
    logic [CHANGE_W-1:0] remaining_q;
    logic [CHANGE_W-1:0] remaining_d;

    // Pieces handed to the hopper so far; held after completion.
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    // Registered status outputs.
    logic                coin_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                drop_q;

    // Greedy pick for the current remaining amount.
    denom_e              sel_code;
    logic [CHANGE_W-1:0] sel_value;

    denom_select #(
        .W (CHANGE_W)
    ) u_denom_select (
        .remaining (remaining_q),
        .code      (sel_code),
        .value     (sel_value)
    );

    // Next-state logic: capture a result, step through pieces, then signal done.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE lasts one cycle.
                // A result arriving in DONE is taken just as it would be in IDLE.
                state_d = IDLE;
                if (bus.valid) begin
                    count_d = '0;
                    if (bus.paid && (bus.change != '0)) begin
                        remaining_d = bus.change;
                        state_d     = DISPENSE;
                    end else begin
                        // Nothing to hand out: complete straight away.
                        state_d = DONE;
                    end
                end
            end

            DISPENSE: begin
                // Incoming results are ignored here.
                // The drop flag records them.
                if (bus.coin_ready) begin
                    // The greedy pick never exceeds the remaining amount,
                    // so this subtraction cannot wrap.
                    remaining_d = remaining_q - sel_value;
                    count_d     = count_q + CNT_W'(1);
                    if (remaining_d == '0) begin
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, amount, counter and status registers.
    // A synchronous reset clears everything, even in mid-transaction.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register here samples values from before this clock edge,
        // independent of statement order.
        if (!i_rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            count_q      <= '0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            count_q      <= count_d;
            // Status lines are registered from the next state, so they line
            // up exactly with the state they describe.
            coin_valid_q <= (state_d == DISPENSE);
            busy_q       <= (state_d == DISPENSE);
            done_q       <= (state_d == DONE);
            drop_q       <= bus.valid && (state_q == DISPENSE);
        end
    end

    // The denom output is a plain decode of the remaining register.
    // It therefore only moves after an accept, and reads zero when idle.
    assign bus.coin_denom = sel_code;
    assign bus.coin_valid = coin_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.coin_count = count_q;
    assign bus.drop       = drop_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser.
// Expected denomination codes are queued when a transaction is started.
// Each piece the hopper accepts is popped from that queue and compared.
module tb_change_dispenser;
    import cashier_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    change_dispenser_if bus ();

    change_dispenser dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Denomination codes the hopper should receive, in order.
    logic [2:0] exp_q [$];

    // Advance one clock.
    // At the falling edge, any piece about to be accepted is compared against
    // the scoreboard.
    // Control then returns 1 time unit after the rising edge.
    task automatic step();
        logic [2:0] e;
        @(negedge clk);
        if (rst_n && bus.coin_valid && bus.coin_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL piece: got denom %0d, expected no piece", bus.coin_denom);
            end else begin
                e = exp_q.pop_front();
                if (bus.coin_denom !== e) begin
                    bad++;
                    $display("FAIL piece: got denom %0d, expected %0d", bus.coin_denom, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle cashier result.
    task automatic start_txn(input logic paid, input logic [15:0] change);
        bus.valid  = 1'b1;
        bus.paid   = paid;
        bus.change = change;
        step();
        bus.valid  = 1'b0;
        bus.paid   = 1'b0;
        bus.change = '0;
    endtask

    // Step until o_done is seen, giving up after a bounded number of cycles.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=%b after %0d cycles, expected 1", bus.done, cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total += 6;
        if (bus.coin_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", bus.coin_valid); end
        if (bus.coin_denom !== 3'd0) begin bad++; $display("FAIL rst_denom: got %0d expected 0", bus.coin_denom); end
        if (bus.busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        if (bus.coin_count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d expected 0", bus.coin_count); end
        if (bus.drop !== 1'b0)       begin bad++; $display("FAIL rst_drop: got %b expected 0", bus.drop); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int cyc;
        exp_q = '{3'd2, 3'd3, 3'd5, 3'd6};
        start_txn(1'b1, 16'd1560);
        total += 2;
        if ({bus.coin_valid, bus.coin_denom} !== {1'b1, 3'd2}) begin
            bad++; $display("FAIL basic_first: got valid=%b denom=%0d expected valid=1 denom=2", bus.coin_valid, bus.coin_denom);
        end
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
        wait_done(cyc);
        total += 4;
        if (cyc != 4)                begin bad++; $display("FAIL basic_latency: got %0d cycles expected 4", cyc); end
        if (bus.coin_count !== 5'd4) begin bad++; $display("FAIL basic_count: got %0d expected 4", bus.coin_count); end
        if (bus.busy !== 1'b0)       begin bad++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL basic_left: got %0d pieces pending expected 0", exp_q.size()); end
        step();
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_max_change();
        int cyc;
        exp_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3,
                  3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        start_txn(1'b1, 16'd65535);
        wait_done(cyc);
        total += 3;
        if (cyc != 16)                begin bad++; $display("FAIL max_latency: got %0d cycles expected 16", cyc); end
        if (bus.coin_count !== 5'd16) begin bad++; $display("FAIL max_count: got %0d expected 16", bus.coin_count); end
        if (exp_q.size() != 0)        begin bad++; $display("FAIL max_left: got %0d pieces pending expected 0", exp_q.size()); end
        step();
    endtask

    task automatic test_stall();
        int cyc;
        exp_q = '{3'd2, 3'd3, 3'd5, 3'd6};
        start_txn(1'b1, 16'd1560);
        step();
        bus.coin_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.coin_valid, bus.coin_denom} !== {1'b1, 3'd3}) begin
                bad++; $display("FAIL stall_hold: got valid=%b denom=%0d expected valid=1 denom=3", bus.coin_valid, bus.coin_denom);
            end
        end
        bus.coin_ready = 1'b1;
        wait_done(cyc);
        total += 3;
        if (cyc != 3)                begin bad++; $display("FAIL stall_latency: got %0d cycles expected 3", cyc); end
        if (bus.coin_count !== 5'd4) begin bad++; $display("FAIL stall_count: got %0d expected 4", bus.coin_count); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL stall_left: got %0d pieces pending expected 0", exp_q.size()); end
        step();
    endtask

    task automatic test_no_pieces();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_txn(1'b0, 16'd500);
            else        start_txn(1'b1, 16'd0);
            total += 4;
            if (bus.coin_valid !== 1'b0) begin bad++; $display("FAIL nopiece_valid%0d: got %b expected 0", k, bus.coin_valid); end
            wait_done(cyc);
            if (cyc != 0)                begin bad++; $display("FAIL nopiece_latency%0d: got %0d cycles expected 0", k, cyc); end
            if (bus.coin_count !== 5'd0) begin bad++; $display("FAIL nopiece_count%0d: got %0d expected 0", k, bus.coin_count); end
            step();
            if (bus.done !== 1'b0)       begin bad++; $display("FAIL nopiece_done_pulse%0d: got %b expected 0", k, bus.done); end
        end
    endtask

    task automatic test_drop();
        int cyc;
        exp_q = '{3'd2, 3'd3, 3'd5, 3'd6};
        start_txn(1'b1, 16'd1560);
        step();
        start_txn(1'b1, 16'd700);
        total++;
        if (bus.drop !== 1'b1) begin bad++; $display("FAIL drop_pulse: got %b expected 1", bus.drop); end
        step();
        total++;
        if (bus.drop !== 1'b0) begin bad++; $display("FAIL drop_clear: got %b expected 0", bus.drop); end
        wait_done(cyc);
        total += 3;
        if (cyc != 1)                begin bad++; $display("FAIL drop_latency: got %0d cycles expected 1", cyc); end
        if (bus.coin_count !== 5'd4) begin bad++; $display("FAIL drop_count: got %0d expected 4", bus.coin_count); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL drop_left: got %0d pieces pending expected 0", exp_q.size()); end
        step();
        total++;
        if ({bus.busy, bus.coin_valid} !== 2'b00) begin
            bad++; $display("FAIL drop_ignored: got busy=%b valid=%b expected 0 0", bus.busy, bus.coin_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        exp_q = '{3'd2, 3'd3, 3'd5, 3'd6};
        start_txn(1'b1, 16'd1560);
        step();
        step();
        rst_n = 1'b0;
        step();
        total += 6;
        if (bus.coin_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b expected 0", bus.coin_valid); end
        if (bus.coin_denom !== 3'd0) begin bad++; $display("FAIL midrst_denom: got %0d expected 0", bus.coin_denom); end
        if (bus.busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0)       begin bad++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        if (bus.coin_count !== 5'd0) begin bad++; $display("FAIL midrst_count: got %0d expected 0", bus.coin_count); end
        if (bus.drop !== 1'b0)       begin bad++; $display("FAIL midrst_drop: got %b expected 0", bus.drop); end
        exp_q.delete();
        rst_n = 1'b1;
        step();
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL midrst_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        exp_q = '{3'd6, 3'd7};
        start_txn(1'b1, 16'd11);
        wait_done(cyc);
        total += 3;
        if (cyc != 2)                begin bad++; $display("FAIL midrst_latency: got %0d cycles expected 2", cyc); end
        if (bus.coin_count !== 5'd2) begin bad++; $display("FAIL midrst_count_new: got %0d expected 2", bus.coin_count); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL midrst_left: got %0d pieces pending expected 0", exp_q.size()); end
    endtask

    // A new result presented during the DONE cycle is accepted immediately.
    task automatic test_back_to_back();
        int cyc;
        total++;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_in_done: got done=%b expected 1", bus.done); end
        exp_q = '{3'd5, 3'd6};
        start_txn(1'b1, 16'd60);
        total++;
        if ({bus.coin_valid, bus.coin_denom} !== {1'b1, 3'd5}) begin
            bad++; $display("FAIL b2b_first: got valid=%b denom=%0d expected valid=1 denom=5", bus.coin_valid, bus.coin_denom);
        end
        wait_done(cyc);
        total += 3;
        if (cyc != 2)                begin bad++; $display("FAIL b2b_latency: got %0d cycles expected 2", cyc); end
        if (bus.coin_count !== 5'd2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", bus.coin_count); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL b2b_left: got %0d pieces pending expected 0", exp_q.size()); end
        step();
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.done); end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.valid      = 1'b0;
        bus.paid       = 1'b0;
        bus.change     = '0;
        bus.coin_ready = 1'b1;

        test_reset();
        test_basic();
        test_max_change();
        test_stall();
        test_no_pieces();
        test_drop();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
